// File: rtl/shift_right_if.sv
// Operand/result bundle for the right barrel shifter.
interface shift_right_if #(
  parameter int NUM_SIZE = 32
);
  localparam int SW = $clog2(NUM_SIZE);

  logic [SW-1:0]       shamt;
  logic [NUM_SIZE-1:0] dIn0;
  logic                arith;
  logic [NUM_SIZE-1:0] dOut;

  modport master (output shamt, output dIn0, output arith, input  dOut);
  modport slave  (input  shamt, input  dIn0, input  arith, output dOut);
endinterface

// File: rtl/shift_right.sv
// Right barrel shifter (SRL/SRA): log2(NUM_SIZE) mux stages, registered result.

// One mux stage: conditionally shift right by SHIFT, back-filling with fill_i.
module shift_right_stage #(
  parameter int NUM_SIZE = 32,
  parameter int SHIFT    = 1
) (
  input  logic [NUM_SIZE-1:0] d_i,
  input  logic                en_i,
  input  logic                fill_i,
  output logic [NUM_SIZE-1:0] d_o
);
  // Pass through unless this stage's shamt bit is set.
  always_comb begin
    d_o = d_i;
    if (en_i) d_o = {{SHIFT{fill_i}}, d_i[NUM_SIZE-1:SHIFT]};
  end
endmodule

module shift_right #(
  parameter int NUM_SIZE = 32
) (
  input  logic          clk,
  input  logic          rst,
  shift_right_if.slave  bus
);
  localparam int SW = $clog2(NUM_SIZE);

  logic                fill;
  logic [NUM_SIZE-1:0] dOut_d;
  logic [NUM_SIZE-1:0] dOut_q;

  // Sign bit only propagates for arithmetic shifts.
  assign fill = bus.arith & bus.dIn0[NUM_SIZE-1];

  // Stage k handles shamt[k] (shift by 2^k); stages chain LSB-first.
  for (genvar k = 0; k < SW; k++) begin : g_stg
    logic [NUM_SIZE-1:0] d_in;
    logic [NUM_SIZE-1:0] d_out;
    if (k == 0) begin : g_first
      assign d_in = bus.dIn0;
    end else begin : g_next
      assign d_in = g_stg[k-1].d_out;
    end
    shift_right_stage #(
      .NUM_SIZE (NUM_SIZE),
      .SHIFT    (1 << k)
    ) u_stage (
      .d_i    (d_in),
      .en_i   (bus.shamt[k]),
      .fill_i (fill),
      .d_o    (d_out)
    );
  end

  assign dOut_d = g_stg[SW-1].d_out;

  // Output register: loads every cycle, reset has priority.
  always_ff @(posedge clk) begin
    if (rst) dOut_q <= '0;
    else     dOut_q <= dOut_d;
  end

  assign bus.dOut = dOut_q;
endmodule

// File: tb/tb_shift_right.sv
// Directed + random checks of shift_right at NUM_SIZE = 32, 8 and 64.
module tb_shift_right;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  shift_right_if #(.NUM_SIZE(32)) bus32 ();
  shift_right_if #(.NUM_SIZE(8))  bus8  ();
  shift_right_if #(.NUM_SIZE(64)) bus64 ();

  shift_right #(.NUM_SIZE(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  shift_right #(.NUM_SIZE(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  shift_right #(.NUM_SIZE(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive 32-bit DUT, step one edge, sample 1 time unit later.
  task automatic step32(input logic [31:0] d, input logic [4:0] s, input logic a);
    bus32.dIn0  = d;
    bus32.shamt = s;
    bus32.arith = a;
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: operand, shamt, arith, expected.
  localparam int NV = 11;
  logic [31:0] v_d   [NV] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
                              32'h8000_0000, 32'h8000_0000, 32'h7000_0000,
                              32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                              32'hDEAD_BEEF, 32'hDEAD_BEEF};
  logic [4:0]  v_s   [NV] = '{5'd0, 5'd1, 5'd31, 5'd4, 5'd31, 5'd4,
                              5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
  logic        v_a   [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] v_e   [NV] = '{32'h8000_0001, 32'h4000_0000, 32'h0000_0001,
                              32'hF800_0000, 32'hFFFF_FFFF, 32'h0700_0000,
                              32'h6F56_DF77, 32'h37AB_6FBB, 32'h0DEA_DBEE,
                              32'h00DE_ADBE, 32'h0000_DEAD};

  initial begin
    logic [31:0] d32, e32;
    logic [7:0]  d8,  e8;
    logic [63:0] d64, e64;
    logic [4:0]  s32;
    logic [2:0]  s8;
    logic [5:0]  s64;
    logic        a32, a8, a64;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus32.dIn0 = 32'hFFFF_FFFF; bus32.shamt = 5'd3; bus32.arith = 1'b0;
    bus8.dIn0  = 8'hFF;         bus8.shamt  = 3'd3; bus8.arith  = 1'b1;
    bus64.dIn0 = '1;            bus64.shamt = 6'd3; bus64.arith = 1'b1;

    // Reset edge clears all outputs, then first edge after release loads data.
    @(posedge clk);
    #1;
    chk("rst32", 64'(bus32.dOut), 64'h0);
    chk("rst8",  64'(bus8.dOut),  64'h0);
    chk("rst64", bus64.dOut,      64'h0);
    rst = 1'b0;
    step32(32'hFFFF_FFFF, 5'd3, 1'b0);
    chk("post_rst", 64'(bus32.dOut), 64'h1FFF_FFFF);

    for (int i = 0; i < NV; i++) begin
      step32(v_d[i], v_s[i], v_a[i]);
      chk($sformatf("vec%0d", i), 64'(bus32.dOut), 64'(v_e[i]));
    end

    // Back-to-back edges: each result must show up on its own cycle only.
    step32(32'hF0F0_F0F0, 5'd4, 1'b0);
    chk("pipe1", 64'(bus32.dOut), 64'h0F0F_0F0F);
    step32(32'hF0F0_F0F0, 5'd4, 1'b1);
    chk("pipe2", 64'(bus32.dOut), 64'hFF0F_0F0F);
    step32(32'h1234_5678, 5'd8, 1'b0);
    chk("pipe3", 64'(bus32.dOut), 64'h0012_3456);

    // Mid-stream reset wins over live data.
    rst = 1'b1;
    step32(32'h8000_0000, 5'd1, 1'b1);
    chk("mid_rst", 64'(bus32.dOut), 64'h0);
    rst = 1'b0;
    step32(32'h8000_0000, 5'd1, 1'b1);
    chk("rst_rel", 64'(bus32.dOut), 64'hC000_0000);

    // Random: all three widths every cycle against the language shift operators.
    for (int n = 0; n < 1000; n++) begin
      d32 = $urandom;  s32 = 5'($urandom_range(0, 31)); a32 = 1'($urandom);
      d8  = 8'($urandom); s8 = 3'($urandom_range(0, 7)); a8 = 1'($urandom);
      d64 = {$urandom, $urandom}; s64 = 6'($urandom_range(0, 63)); a64 = 1'($urandom);
      if (a32) e32 = $signed(d32) >>> s32; else e32 = d32 >> s32;
      if (a8)  e8  = $signed(d8)  >>> s8;  else e8  = d8  >> s8;
      if (a64) e64 = $signed(d64) >>> s64; else e64 = d64 >> s64;
      bus8.dIn0  = d8;  bus8.shamt  = s8;  bus8.arith  = a8;
      bus64.dIn0 = d64; bus64.shamt = s64; bus64.arith = a64;
      step32(d32, s32, a32);
      chk("rnd32", 64'(bus32.dOut), 64'(e32));
      chk("rnd8",  64'(bus8.dOut),  64'(e8));
      chk("rnd64", bus64.dOut,      e64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_right.md
# shift_right

Parameterised right barrel shifter for the RV32I datapath, serving SRL/SRLI and SRA/SRAI. It shifts a NUM_SIZE-bit operand right by a binary shift amount through log2(NUM_SIZE) mux stages. The result is captured in an output register, so the block adds exactly one pipeline stage in the execute path.

## Interface
- NUM_SIZE, 32, operand/result width in bits; power of two, at least 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- shamt  input  $clog2(NUM_SIZE)  unsigned shift amount, 0..NUM_SIZE-1.
- dIn0  input  NUM_SIZE  operand to shift.
- arith  input  1  0 = logical shift (zero fill), 1 = arithmetic shift (fill with dIn0[NUM_SIZE-1]).
- dOut  output  NUM_SIZE  registered shift result.

## Operation
- Fill bit: fill = arith & dIn0[NUM_SIZE-1].
- Shift network: $clog2(NUM_SIZE) cascaded stages. Stage k shifts right by 2^k when shamt[k]=1, otherwise it passes its input through.
  - Vacated MSBs in each stage take the value fill.
  - Stage 0 takes dIn0. The last stage drives the next-state value of dOut.
- Combinational result, for i in 0..NUM_SIZE-1:
  - res[i] = dIn0[i+shamt] when i+shamt < NUM_SIZE.
  - res[i] = fill otherwise.
- shamt = 0: res = dIn0, whatever arith is.
- shamt = NUM_SIZE-1, arith=0: res = {NUM_SIZE-1 zeros, dIn0[NUM_SIZE-1]}.
- shamt = NUM_SIZE-1, arith=1: res = all bits equal to dIn0[NUM_SIZE-1].
- shamt has no out-of-range value, because its width exactly covers 0..NUM_SIZE-1. There is no masking or saturation logic.
- No X-propagation special cases. The block has no internal state other than the dOut register.

## Timing
- On every rising edge of clk:
  - rst=1: dOut <= 0.
  - rst=0: dOut <= res computed from that edge's dIn0, shamt and arith.
- Reset value of dOut: all zeros. rst has priority over new data on the same edge.
- Latency: 1 cycle. Inputs sampled at edge N appear on dOut after edge N. There is no enable; the register loads every cycle.
- Throughput: one new operation per cycle, with no handshake and no stall.
- Inputs may change on every cycle, and each edge's result depends only on that edge's inputs.
- Reset asserted mid-stream: the next edge clears dOut to 0.
- After rst deasserts, the first edge loads a valid result.

## Test plan
- Reset: drive dIn0=32'hFFFF_FFFF, shamt=3, rst=1 for one edge -> dOut=32'h0000_0000. Release rst; after the next edge -> dOut=32'h1FFF_FFFF.
- Logical shift: dIn0=32'h8000_0001, arith=0.
  - shamt=0 -> 32'h8000_0001.
  - shamt=1 -> 32'h4000_0000.
  - shamt=31 -> 32'h0000_0001.
- Arithmetic shift: dIn0=32'h8000_0000, arith=1.
  - shamt=4 -> 32'hF800_0000.
  - shamt=31 -> 32'hFFFF_FFFF.
  - dIn0=32'h7000_0000, shamt=4 -> 32'h0700_0000 (positive operand, zero fill).
- Each stage alone: dIn0=32'hDEAD_BEEF, arith=0.
  - shamt=1 -> 32'h6F56_DF77.
  - shamt=2 -> 32'h37AB_6FBB.
  - shamt=4 -> 32'h0DEA_DBEE.
  - shamt=8 -> 32'h00DE_ADBE.
  - shamt=16 -> 32'h0000_DEAD.
- Pipelining: apply back-to-back inputs on consecutive edges:
  - edge 1: dIn0=32'hF0F0_F0F0, shamt=4, arith=0 -> 32'h0F0F_0F0F.
  - edge 2: dIn0=32'hF0F0_F0F0, shamt=4, arith=1 -> 32'hFF0F_0F0F.
  - edge 3: dIn0=32'h1234_5678, shamt=8, arith=0 -> 32'h0012_3456.
  - Each result must appear exactly one cycle after its inputs, and no result may persist into a later cycle.
- Random: 1000 random (dIn0, shamt, arith) vectors. Each cycle's dOut must equal the previous cycle's reference.
  - arith=0: reference = dIn0 >> shamt.
  - arith=1: reference = $signed(dIn0) >>> shamt.
  - Repeat the random run with NUM_SIZE=8 and NUM_SIZE=64.
